// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer producing every alu_system control input.
// Optional macro CU_ILLEGAL_TRAP_EN: illegal opcodes halt and set the sticky illegal flag.
module control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  IROutMSB,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        MuxDSel,
  output logic [3:0]  RFRegSel,
  output logic [3:0]  RFScrSel,
  output logic [2:0]  RFFunSel,
  output logic [2:0]  RFOutASel,
  output logic [2:0]  RFOutBSel,
  output logic [4:0]  ALUFunSel,
  output logic [2:0]  ARFRegSel,
  output logic [1:0]  ARFFunSel,
  output logic [1:0]  ARFOutASel,
  output logic [1:0]  ARFOutBSel,
  output logic        DREnable,
  output logic [1:0]  DRFunSel,
  output logic        MemCS,
  output logic        MemWR,
  output logic        IRHighSel,
  output logic        IRWrite,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH_L, ST_FETCH_H, ST_WAIT, ST_EXEC, ST_HALT
  } state_t;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_LDI  = 6'h01;
  localparam logic [5:0] OP_INC  = 6'h02;
  localparam logic [5:0] OP_ADD  = 6'h03;
  localparam logic [5:0] OP_HALT = 6'h3F;

  state_t     state;
  state_t     state_next;
  logic [5:0] opcode;
  logic [1:0] rx;
  logic [3:0] rx_onehot;
  logic       op_halt;
  logic       retire;

  assign opcode    = IROutMSB[7:2];
  assign rx        = IROutMSB[1:0];
  assign rx_onehot = 4'b0001 << rx;
  assign op_halt   = (opcode == OP_HALT);

`ifdef CU_ILLEGAL_TRAP_EN
  logic op_legal;
  logic trap;
  logic illegal_reg;

  assign op_legal = (opcode <= OP_ADD);
  assign trap     = (state == ST_EXEC) && !op_legal && !op_halt;
  assign retire   = (state == ST_EXEC) && op_legal;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      illegal_reg <= 1'b0;
    else if (trap)
      illegal_reg <= 1'b1;
  end

  assign illegal = illegal_reg;
`else
  // Unknown opcodes behave as NOP and still retire.
  assign retire  = (state == ST_EXEC) && !op_halt;
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      instr_count <= 16'd0;
    end else begin
      state <= state_next;
      if (retire)
        instr_count <= instr_count + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    MuxASel    = 2'b00;
    MuxBSel    = 2'b00;
    MuxCSel    = 2'b00;
    MuxDSel    = 1'b0;
    RFRegSel   = 4'b0000;
    RFScrSel   = 4'b0000;
    RFFunSel   = 3'b000;
    RFOutASel  = 3'b000;
    RFOutBSel  = 3'b000;
    ALUFunSel  = 5'b00000;
    ARFRegSel  = 3'b000;
    ARFFunSel  = 2'b00;
    ARFOutASel = 2'b00;
    ARFOutBSel = 2'b00;
    DREnable   = 1'b0;
    DRFunSel   = 2'b00;
    MemCS      = 1'b1;
    MemWR      = 1'b0;
    IRHighSel  = 1'b0;
    IRWrite    = 1'b0;
    busy       = (state != ST_IDLE) && (state != ST_HALT);
    halted     = (state == ST_HALT);

    case (state)
      ST_IDLE: begin
        if (run)
          state_next = ST_FETCH_L;
      end
      ST_FETCH_L, ST_FETCH_H: begin
        // Read memory at PC into the selected IR half, post-incrementing PC.
        MemCS      = 1'b0;
        ARFOutBSel = 2'b00;
        IRWrite    = 1'b1;
        IRHighSel  = (state == ST_FETCH_H);
        ARFRegSel  = 3'b001;
        ARFFunSel  = 2'b01;
        state_next = (state == ST_FETCH_L) ? ST_FETCH_H : ST_WAIT;
      end
      ST_WAIT: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode)
          OP_LDI: begin
            MuxASel  = 2'b11;
            RFFunSel = 3'b010;
            RFRegSel = rx_onehot;
          end
          OP_INC: begin
            RFFunSel = 3'b001;
            RFRegSel = rx_onehot;
          end
          OP_ADD: begin
            MuxDSel   = 1'b0;
            RFOutASel = {1'b0, rx};
            RFOutBSel = 3'b000;
            ALUFunSel = 5'b10100;
            MuxASel   = 2'b00;
            RFFunSel  = 3'b010;
            RFRegSel  = rx_onehot;
          end
          default: ;
        endcase

        if (op_halt)
          state_next = ST_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
        else if (!op_legal)
          state_next = ST_HALT;
`endif
        else if (run)
          state_next = ST_FETCH_L;
        else
          state_next = ST_IDLE;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized
// instruction streams checked against a per-phase expectation model.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  IROutMSB;
  logic [1:0]  MuxASel, MuxBSel, MuxCSel;
  logic        MuxDSel;
  logic [3:0]  RFRegSel, RFScrSel;
  logic [2:0]  RFFunSel, RFOutASel, RFOutBSel;
  logic [4:0]  ALUFunSel;
  logic [2:0]  ARFRegSel;
  logic [1:0]  ARFFunSel, ARFOutASel, ARFOutBSel;
  logic        DREnable;
  logic [1:0]  DRFunSel;
  logic        MemCS, MemWR, IRHighSel, IRWrite;
  logic        busy, halted, illegal;
  logic [15:0] instr_count;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .reset(reset), .run(run), .IROutMSB(IROutMSB),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel),
    .RFRegSel(RFRegSel), .RFScrSel(RFScrSel), .RFFunSel(RFFunSel),
    .RFOutASel(RFOutASel), .RFOutBSel(RFOutBSel), .ALUFunSel(ALUFunSel),
    .ARFRegSel(ARFRegSel), .ARFFunSel(ARFFunSel),
    .ARFOutASel(ARFOutASel), .ARFOutBSel(ARFOutBSel),
    .DREnable(DREnable), .DRFunSel(DRFunSel), .MemCS(MemCS), .MemWR(MemWR),
    .IRHighSel(IRHighSel), .IRWrite(IRWrite), .busy(busy), .halted(halted),
    .illegal(illegal), .instr_count(instr_count)
  );

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] mux_a, mux_b, mux_c;
    logic       mux_d;
    logic [3:0] rf_reg, rf_scr;
    logic [2:0] rf_fun, out_a, out_b;
    logic [4:0] alu;
    logic [2:0] arf_reg;
    logic [1:0] arf_fun, arf_out_a, arf_out_b;
    logic       dr_en;
    logic [1:0] dr_fun;
    logic       mem_cs, mem_wr, ir_high, ir_write, busy, halted;
  } ctl_t;

  ctl_t obs;
  assign obs = {MuxASel, MuxBSel, MuxCSel, MuxDSel, RFRegSel, RFScrSel, RFFunSel,
                RFOutASel, RFOutBSel, ALUFunSel, ARFRegSel, ARFFunSel, ARFOutASel,
                ARFOutBSel, DREnable, DRFunSel, MemCS, MemWR, IRHighSel, IRWrite,
                busy, halted};

  localparam int P_IDLE = 0, P_FL = 1, P_FH = 2, P_WAIT = 3, P_EXEC = 4, P_HALT = 5;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  // Expected control word for a given instruction phase, straight from the opcode table.
  function automatic ctl_t expect_ctl(input int phase, input logic [7:0] ir);
    ctl_t c;
    int op, r;
    c = '0;
    c.mem_cs = 1'b1;
    op = int'(ir) / 4;
    r  = int'(ir) % 4;
    case (phase)
      P_FL, P_FH: begin
        c.mem_cs = 1'b0; c.ir_write = 1'b1; c.ir_high = (phase == P_FH);
        c.arf_reg = 3'b001; c.arf_fun = 2'b01; c.busy = 1'b1;
      end
      P_WAIT: c.busy = 1'b1;
      P_EXEC: begin
        c.busy = 1'b1;
        if (op == 1) begin
          c.mux_a = 2'b11; c.rf_fun = 3'b010; c.rf_reg = 4'(1 << r);
        end else if (op == 2) begin
          c.rf_fun = 3'b001; c.rf_reg = 4'(1 << r);
        end else if (op == 3) begin
          c.out_a = 3'(r); c.alu = 5'b10100; c.rf_fun = 3'b010; c.rf_reg = 4'(1 << r);
        end
      end
      P_HALT: c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic bit retires(input logic [7:0] ir);
    int op;
    op = int'(ir) / 4;
    if (op <= 3) return 1'b1;
    if (op == 63) return 1'b0;
    return !TRAP;
  endfunction

  task automatic chk_ctl(input string tag, input ctl_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Runs one instruction; caller ensures the next edge enters FETCH_L.
  // drop_at (1..4) deasserts run after checking that phase; other values keep it.
  task automatic exec_instr(input logic [7:0] ir, input int drop_at);
    step(); chk_ctl("fetch_l", expect_ctl(P_FL, ir));
    IROutMSB = 8'($urandom);
    if (drop_at == 1) run = 1'b0;
    step(); chk_ctl("fetch_h", expect_ctl(P_FH, ir));
    if (drop_at == 2) run = 1'b0;
    step(); chk_ctl("wait", expect_ctl(P_WAIT, ir));
    IROutMSB = ir;
    if (drop_at == 3) run = 1'b0;
    step(); chk_ctl("exec", expect_ctl(P_EXEC, ir));
    chk_val("count_exec", instr_count, 16'(model_count));
    if (drop_at == 4) run = 1'b0;
    if (retires(ir)) model_count = (model_count + 1) % 65536;
  endtask

  task automatic idle_check(input string tag);
    chk_ctl(tag, expect_ctl(P_IDLE, 8'h00));
    chk_val({tag, "_count"}, instr_count, 16'(model_count));
  endtask

  initial begin
    logic [7:0] ir;
    run = 1'b0;
    IROutMSB = 8'h00;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      idle_check("reset_idle");
      chk_val("reset_illegal", {15'd0, illegal}, 16'd0);
    end

    // LDI R3 with run held, then ADD R1 with run dropped during FETCH_H.
    run = 1'b1;
    exec_instr(8'h06, 9);
    exec_instr(8'h0C, 2);
    step(); idle_check("after_drop");

    for (int n = 0; n < 40; n++) begin
      ir = 8'($urandom);
      if ((ir[7:2] == 6'h3F) || (TRAP && ir[7:2] > 6'd3)) ir = ir & 8'h0F;
      run = 1'b1;
      exec_instr(ir, int'($urandom_range(1, 7)));
      if (!run) begin
        step(); idle_check("rand_idle");
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          step(); idle_check("rand_linger");
        end
      end
    end
    run = 1'b0;
    step(); idle_check("loop_end");

    // Illegal opcode 0x40.
    run = 1'b1;
    exec_instr(8'h40, 4);
    step();
    if (TRAP) begin
      chk_ctl("illegal_halt", expect_ctl(P_HALT, 8'h00));
      chk_val("illegal_flag", {15'd0, illegal}, 16'd1);
      chk_val("illegal_count", instr_count, 16'(model_count));
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      model_count = 0;
      chk_val("illegal_cleared", {15'd0, illegal}, 16'd0);
    end else begin
      idle_check("illegal_nop");
      chk_val("illegal_flag", {15'd0, illegal}, 16'd0);
    end

    // Asynchronous reset in the middle of an instruction.
    run = 1'b1;
    step(); chk_ctl("abort_fl", expect_ctl(P_FL, 8'h00));
    step(); chk_ctl("abort_fh", expect_ctl(P_FH, 8'h00));
    #2 reset = 1'b0;
    #1;
    model_count = 0;
    idle_check("async_reset");
    @(negedge clock);
    reset = 1'b1;
    run = 1'b0;
    step(); idle_check("post_reset");

    // HALT: only reset leaves it.
    run = 1'b1;
    exec_instr(8'hFC, 9);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_ctl("halt_hold", expect_ctl(P_HALT, 8'h00));
      chk_val("halt_count", instr_count, 16'(model_count));
      run = 1'($urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired sequencer driving the control inputs of `alu_system`. It fetches a 16-bit instruction as two byte reads from memory at PC, low byte first, into the IR. It decodes the registered opcode byte returned on `IROutMSB` and issues the micro-operations for a small instruction set. Upstream of `alu_system`: every datapath select and enable comes from this block.

## Interface
- No parameters.
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- run  in  1  start/continue request, sampled in IDLE
- IROutMSB  in  8  opcode byte from `alu_system`; [7:2] opcode, [1:0] Rx (00=R1..11=R4)
- MuxASel/MuxBSel/MuxCSel  out  2 each  00 ALUOut, 01 ARFOutC, 10 DROut, 11 IROut
- MuxDSel  out  1  0 = RFOutA
- RFRegSel, RFScrSel  out  4 each  bit i = 1 enables R(i+1) / S(i+1)
- RFFunSel  out  3  001 increment, 010 load
- RFOutASel, RFOutBSel  out  3 each  000..011 = R1..R4
- ALUFunSel  out  5  10100 = 32-bit A+B
- ARFRegSel  out  3  bit0 = PC
- ARFFunSel  out  2  01 increment
- ARFOutASel, ARFOutBSel  out  2 each  00 = PC
- DREnable  out  1;  DRFunSel  out  2
- MemCS  out  1  active-low
- MemWR  out  1  1 = write
- IRHighSel  out  1  0 = low byte, 1 = high byte
- IRWrite  out  1
- busy  out  1  high in any state except IDLE/HALT
- halted  out  1  high in HALT
- illegal  out  1  sticky illegal-opcode flag
- instr_count  out  16  retired-instruction counter

## Operation
- States: IDLE, FETCH_L, FETCH_H, WAIT, EXEC, HALT.
- Idle drive, in every state unless listed below: all RegSel/ScrSel = 0, MemCS=1, MemWR=0, IRWrite=0, DREnable=0, selects = 0.
- IDLE: run=1 -> FETCH_L, else hold.
- FETCH_L: MemCS=0, ARFOutBSel=00, IRWrite=1, IRHighSel=0, ARFRegSel=001, ARFFunSel=01 (PC++). Next state FETCH_H.
- FETCH_H: same as FETCH_L with IRHighSel=1. Next state WAIT.
- WAIT: no outputs active. Covers the registered `IROutMSB` delay. Next state EXEC.
- EXEC: decode `IROutMSB` combinationally; one-hot(Rx) = 1 << Rx.
  - 0x00 NOP: nothing.
  - 0x01 LDI: MuxASel=11, RFFunSel=010, RFRegSel=one-hot(Rx).
  - 0x02 INC: RFFunSel=001, RFRegSel=one-hot(Rx).
  - 0x03 ADD (Rx <- Rx+R1): MuxDSel=0, RFOutASel=Rx, RFOutBSel=000, ALUFunSel=10100, MuxASel=00, RFFunSel=010, RFRegSel=one-hot(Rx).
  - 0x3F HALT: -> HALT.
  - Any other opcode: illegal, see Configuration.
- After EXEC (non-halt): run=1 -> FETCH_L; run=0 -> IDLE.
- HALT: exits only via reset.
- instr_count: +1 at the end of EXEC for NOP/LDI/INC/ADD only; wraps 0xFFFF -> 0x0000.

## Timing
- Reset (async assert): state=IDLE, all outputs at idle drive, busy=0, halted=0, illegal=0, instr_count=0. Reset mid-instruction aborts immediately, with no partial retire.
- Instruction latency: exactly 4 cycles (FETCH_L..EXEC), back-to-back with run held high.
- First FETCH_L follows the cycle in which IDLE samples run=1.
- run is ignored outside IDLE and EXEC. Deasserting run mid-instruction always completes that instruction.
- All outputs are Moore on state, except EXEC controls, which also depend on `IROutMSB`.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined: illegal opcode in EXEC -> HALT, illegal=1 sticky, instr_count unchanged.
- Undefined: illegal opcode executes as NOP and is counted; illegal is tied 0.

## Test plan
- Reset low for 3 cycles, release with run=0 -> IDLE; MemCS=1, busy=0, instr_count=0 for 10 cycles.
- run=1, IROutMSB=0x06 (LDI R3) in EXEC -> cycle 4 shows MuxASel=11, RFFunSel=010, RFRegSel=0100; instr_count=1; ARFFunSel=01 pulsed twice.
- IROutMSB=0x0C (ADD R1) -> RFOutASel=000, RFOutBSel=000, ALUFunSel=10100, RFRegSel=0001.
- run dropped during FETCH_H -> instruction completes, then IDLE; busy falls after EXEC.
- IROutMSB=0xFC -> HALT, halted=1; run toggling has no effect until reset.
- IROutMSB=0x40 -> with `CU_ILLEGAL_TRAP_EN`: illegal=1, halted=1, count held. Without it: NOP, count+1, illegal=0.
